fft_out_reorder: RTL
====================

# fft_out_reorder

Output-side reorder buffer that sits downstream of `fft_top` and consumes its `out_push_F`/`out_real_F`/`out_imag_F` stream, answering with `out_stall`. Each 16-sample FFT result frame arrives in bit-reversed index order. The block writes it into one bank of a 2×16 ping-pong buffer at the bit-reversed address, then replays it in natural order 0..15 on a push/stall stream of the same form. One bank fills while the other drains, sustaining 1 sample/cycle.

## Interface
Parameters:
- `DATA_W`, 16: width of each real/imag component.
- `BIT_REVERSE`, 1: 1 = write address is bitrev4(count); 0 = write address is count (pass-through order).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_push`  in  1  sample valid; connect to `fft_top.out_push_F`.
- `in_real`  in  DATA_W  real part.
- `in_imag`  in  DATA_W  imaginary part.
- `in_stall`  out  1  cannot accept; connect to `fft_top.out_stall`.
- `out_push_F`  out  1  registered output-sample valid.
- `out_real_F`  out  DATA_W  registered real part.
- `out_imag_F`  out  DATA_W  registered imaginary part.
- `out_stall`  in  1  downstream cannot accept.
- `overflow_F`  out  1  sticky protocol-error flag.

## Operation
- State: `wbank`, `rbank` (1 bit each), `wcnt`, `rcnt` (4 bits each), `full[1:0]`.
- Fill: `in_stall = full[wbank]` (combinational).
  - Accept a sample when `in_push && !in_stall`: write `{in_real,in_imag}` to `mem[wbank][addr]`, with `addr = BIT_REVERSE ? bitrev4(wcnt) : wcnt`, then `wcnt++`.
  - On the 16th accept (`wcnt == 15`): set `full[wbank]`, toggle `wbank`, and wrap `wcnt` to 0.
- Drain:
  - Advance when `full[rbank] && !out_stall`. The read of `mem[rbank][rcnt]` is combinational; on the next edge `out_push_F <= 1` and the data registers load, then `rcnt++`.
  - Otherwise `out_push_F <= 0` and the data registers hold.
  - On the advance with `rcnt == 15`: clear `full[rbank]`, toggle `rbank`, and wrap `rcnt` to 0.
- Simultaneous set and clear of `full` in the same cycle always target different banks; both take effect.
- A push while `in_stall = 1` is dropped (no write, no count change) and sets `overflow_F = 1` until reset.
- Output data is complex, `{real, imag}` packed into 2·DATA_W bits, and passes through bit-exact with no arithmetic.

## Timing
- Reset (async assert, sync-safe deassert): `out_push_F = 0`, `out_real_F = 0`, `out_imag_F = 0`, `overflow_F = 0`. Also `full = 0`, all counters and bank pointers 0, so `in_stall = 0`.
- Latency: if the 16th sample of a frame is accepted in cycle t, the first `out_push_F` occurs in cycle t+2 (when `out_stall` is low in cycle t+1).
- Output handshake: a push in cycle t+1 happens only if `out_stall` was low in cycle t. Downstream must therefore accept the one push that lands in the cycle it raises `out_stall`.
- Input handshake: zero-cycle. Upstream must not push in a cycle with `in_stall` high.
- With `out_stall = 0` and continuous input, `in_stall` never asserts: bank reuse and bank free happen on the same edge.
- Reset mid-frame discards all buffered data. The first post-reset frame behaves as the first after power-up.

## Structure
- Shared package `fft_pkg`:
  - constants `FFT_N = 16`, `FFT_LOG2N = 4`, `SAMPLE_W = 16`;
  - function `bitrev4`;
  - typedef `cplx_t` for the packed `{real, imag}` sample.
- Sub-module `pingpong_ram_32x32`: 32 entries, one write port, one combinational read port, address `{bank, idx}`, no reset on contents.
- Top level holds the counters, `full` flags, handshake logic and output registers.

## Test plan
- Single frame: input `real = k`, `imag = 16'h100 + k`, k = 0..15, `out_stall = 0`, `BIT_REVERSE = 1`.
  - Output `real` sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with `imag = 0x100 + real`.
  - First push arrives 2 cycles after the last input.
- Three back-to-back frames, 48 cycles of continuous `in_push`, `out_stall = 0`:
  - `in_stall` is never 1 and `overflow_F` stays 0;
  - 48 outputs in per-frame natural order, with no gap between frames.
- `out_stall` held at 1 from reset while 40 pushes are attempted under correct protocol:
  - `in_stall` rises after 32 accepts and `out_push_F` stays 0;
  - after releasing `out_stall`, 32 pushes follow (frame 1, then frame 2) and `in_stall` drops after the 16th.
- `out_stall` toggling 1010... during a drain:
  - each push follows a stall-low cycle;
  - all 16 samples arrive once, in order, with none lost or duplicated.
- Push while `in_stall = 1` (both banks full):
  - the sample is ignored and `overflow_F` goes to 1 and stays there through later valid frames;
  - only reset clears it.
- Reset pulse after 5 outputs of a drain:
  - all outputs are 0 at once and `in_stall = 0`;
  - a fresh frame is then reordered correctly.
  - Repeat the single-frame test with `BIT_REVERSE = 0`: output `real` is 0..15 in order.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, the packed complex sample type and index helpers.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int SAMPLE_W  = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] rev;
    rev = 4'd0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      rev[b] = idx[FFT_LOG2N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_out_reorder_ram.sv
// Two-bank sample store: synchronous write, combinational read, address {bank, idx}.
module pingpong_ram_32x32
  import fft_pkg::*;
#(
  parameter int W = 2 * SAMPLE_W
) (
  input  logic         clk,
  input  logic         wr_en_i,
  input  logic [4:0]   wr_addr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic [4:0]   rd_addr_i,
  output logic [W-1:0] rd_data_o
);

  logic [W-1:0] mem_q [32];

  // Contents are deliberately not reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT result frames into natural order through a ping-pong buffer.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W      = SAMPLE_W,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              in_stall,
  output logic              out_push_F,
  output logic [DATA_W-1:0] out_real_F,
  output logic [DATA_W-1:0] out_imag_F,
  input  logic              out_stall,
  output logic              overflow_F
);

  localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(FFT_N - 1);

  logic                    wbank_q, wbank_d, rbank_q, rbank_d;
  logic [FFT_LOG2N-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]              full_q, full_d;
  logic                    push_q, push_d, ovf_q, ovf_d;
  logic [DATA_W-1:0]       real_q, real_d, imag_q, imag_d;

  logic                    accept_s, advance_s, wr_last_s, rd_last_s;
  logic [1:0]              set_s, clr_s;
  logic [FFT_LOG2N-1:0]    waddr_s;
  logic [2*DATA_W-1:0]     rd_data_s;

  assign in_stall  = full_q[wbank_q];
  assign accept_s  = in_push & ~in_stall;
  assign advance_s = full_q[rbank_q] & ~out_stall;
  assign waddr_s   = BIT_REVERSE ? bitrev4(wcnt_q) : wcnt_q;
  assign wr_last_s = accept_s & (wcnt_q == LAST_IDX);
  assign rd_last_s = advance_s & (rcnt_q == LAST_IDX);

  pingpong_ram_32x32 #(.W(2 * DATA_W)) u_ram (
    .clk       (clk),
    .wr_en_i   (accept_s),
    .wr_addr_i ({wbank_q, waddr_s}),
    .wr_data_i ({in_real, in_imag}),
    .rd_addr_i ({rbank_q, rcnt_q}),
    .rd_data_o (rd_data_s)
  );

  // Next-state: set and clear of full never hit the same bank, so both apply.
  always_comb begin
    set_s   = wr_last_s ? (2'b01 << wbank_q) : 2'b00;
    clr_s   = rd_last_s ? (2'b01 << rbank_q) : 2'b00;
    full_d  = (full_q | set_s) & ~clr_s;
    wbank_d = wr_last_s ? ~wbank_q : wbank_q;
    rbank_d = rd_last_s ? ~rbank_q : rbank_q;
    wcnt_d  = accept_s ? wcnt_q + 4'd1 : wcnt_q;
    rcnt_d  = advance_s ? rcnt_q + 4'd1 : rcnt_q;
    push_d  = advance_s;
    real_d  = advance_s ? rd_data_s[2*DATA_W-1:DATA_W] : real_q;
    imag_d  = advance_s ? rd_data_s[DATA_W-1:0] : imag_q;
    ovf_d   = ovf_q | (in_push & in_stall);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
      full_q  <= 2'b00;
      push_q  <= 1'b0;
      real_q  <= '0;
      imag_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      full_q  <= full_d;
      push_q  <= push_d;
      real_q  <= real_d;
      imag_q  <= imag_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_push_F = push_q;
  assign out_real_F = real_q;
  assign out_imag_F = imag_q;
  assign overflow_F = ovf_q;

endmodule
